// File: rtl/if_fetch_if.sv
// Instruction-memory request/ack bus between the fetch stage and instruction memory.
//   inst_req_o    fetch -> mem   request strobe, held until ack
//   inst_addr_o   fetch -> mem   request address
//   inst_ack_i    mem -> fetch   one-cycle ack, rdata valid in the same cycle
//   inst_rdata_i  mem -> fetch   fetched instruction word
// master: the fetch stage. slave: the instruction memory.
interface if_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              inst_req_o;
   logic [ADDR_W-1:0] inst_addr_o;
   logic              inst_ack_i;
   logic [INST_W-1:0] inst_rdata_i;

   modport master (
      output inst_req_o,
      output inst_addr_o,
      input  inst_ack_i,
      input  inst_rdata_i
   );

   modport slave (
      input  inst_req_o,
      input  inst_addr_o,
      output inst_ack_i,
      output inst_rdata_i
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, issues one request at a time to instruction memory, and holds
// one extra instruction in a skid buffer when IF/ID stalls. Branch redirects
// flush undelivered work.
// Ports:
//   clk              clock, all state on posedge
//   rst              asynchronous active-low reset
//   stall_i          IF/ID cannot accept this cycle
//   branch_flag_i    redirect pulse from ID
//   branch_target_i  redirect PC, valid with branch_flag_i
//   imem             instruction-memory bus (master side)
//   if_pc            PC of the presented instruction
//   if_inst          presented instruction, 0 when !if_valid
//   if_valid         if_pc/if_inst hold a real instruction
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32,
   parameter int          INST_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   if_fetch_if.master        imem,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst,
   output logic              if_valid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_FULL = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);
   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

   state_t            state_r,      state_next_s;
   logic [ADDR_W-1:0] pc_r,         pc_next_s;
   logic [ADDR_W-1:0] addr_r,       addr_next_s;
   logic              req_r,        req_next_s;
   logic [ADDR_W-1:0] if_pc_r,      if_pc_next_s;
   logic [INST_W-1:0] if_inst_r,    if_inst_next_s;
   logic              if_valid_r,   if_valid_next_s;
   logic [ADDR_W-1:0] skid_pc_r,    skid_pc_next_s;
   logic [INST_W-1:0] skid_inst_r,  skid_inst_next_s;
   logic              slot_free_s;
   logic              ack_s;

   // Next-state, PC, output-slot and skid-buffer logic
   always_comb begin
      state_next_s     = state_r;
      pc_next_s        = pc_r;
      if_pc_next_s     = if_pc_r;
      if_inst_next_s   = if_inst_r;
      if_valid_next_s  = if_valid_r;
      skid_pc_next_s   = skid_pc_r;
      skid_inst_next_s = skid_inst_r;

      slot_free_s = !if_valid_r || !stall_i;
      // An ack only counts against a request we are actually driving.
      ack_s       = imem.inst_ack_i && req_r;

      // A free slot with nothing loaded presents a nop.
      if (slot_free_s) begin
         if_valid_next_s = 1'b0;
         if_inst_next_s  = {INST_W{1'b0}};
      end else begin
         if_valid_next_s = if_valid_r;
         if_inst_next_s  = if_inst_r;
      end

      if (branch_flag_i) begin
         if_valid_next_s  = 1'b0;
         if_inst_next_s   = {INST_W{1'b0}};
         skid_pc_next_s   = {ADDR_W{1'b0}};
         skid_inst_next_s = {INST_W{1'b0}};
         pc_next_s        = branch_target_i;
         case (state_r)
            // Unacked request is still in flight at memory: drain it first.
            ST_REQ:  state_next_s = ack_s ? ST_REQ : ST_DROP;
            ST_DROP: state_next_s = ST_DROP;
            default: state_next_s = ST_REQ;
         endcase
      end else begin
         case (state_r)
            ST_IDLE: state_next_s = ST_REQ;
            ST_REQ: begin
               if (ack_s) begin
                  pc_next_s = pc_r + PC_STEP;
                  if (slot_free_s) begin
                     if_pc_next_s    = pc_r;
                     if_inst_next_s  = imem.inst_rdata_i;
                     if_valid_next_s = 1'b1;
                  end else begin
                     skid_pc_next_s   = pc_r;
                     skid_inst_next_s = imem.inst_rdata_i;
                     state_next_s     = ST_FULL;
                  end
               end else begin
                  state_next_s = ST_REQ;
               end
            end
            ST_FULL: begin
               if (!stall_i) begin
                  if_pc_next_s     = skid_pc_r;
                  if_inst_next_s   = skid_inst_r;
                  if_valid_next_s  = 1'b1;
                  skid_pc_next_s   = {ADDR_W{1'b0}};
                  skid_inst_next_s = {INST_W{1'b0}};
                  state_next_s     = ST_REQ;
               end else begin
                  state_next_s = ST_FULL;
               end
            end
            ST_DROP: begin
               if (ack_s) begin
                  state_next_s = ST_REQ;
               end else begin
                  state_next_s = ST_DROP;
               end
            end
            default: state_next_s = ST_IDLE;
         endcase
      end

      // The bus address follows the PC, except while draining a stale request:
      // memory still sees the old address until that request is acked, while
      // pc already holds the redirect target.
      if (state_next_s == ST_DROP) begin
         addr_next_s = addr_r;
      end else begin
         addr_next_s = pc_next_s;
      end

      req_next_s = (state_next_s == ST_REQ) || (state_next_s == ST_DROP);
   end

   // State, PC, bus and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         pc_r        <= PC_INIT;
         addr_r      <= PC_INIT;
         req_r       <= 1'b0;
         if_pc_r     <= {ADDR_W{1'b0}};
         if_inst_r   <= {INST_W{1'b0}};
         if_valid_r  <= 1'b0;
         skid_pc_r   <= {ADDR_W{1'b0}};
         skid_inst_r <= {INST_W{1'b0}};
      end else begin
         state_r     <= state_next_s;
         pc_r        <= pc_next_s;
         addr_r      <= addr_next_s;
         req_r       <= req_next_s;
         if_pc_r     <= if_pc_next_s;
         if_inst_r   <= if_inst_next_s;
         if_valid_r  <= if_valid_next_s;
         skid_pc_r   <= skid_pc_next_s;
         skid_inst_r <= skid_inst_next_s;
      end
   end

   assign imem.inst_req_o  = req_r;
   assign imem.inst_addr_o = addr_r;
   assign if_pc            = if_pc_r;
   assign if_inst          = if_inst_r;
   assign if_valid         = if_valid_r;

endmodule
